// File: rtl/ysyx_22041412_cache_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041412_cache_rd_arb_pkg
//  Description : Shared definitions for the I/D cache refill read arbiter.
//                Holds the default bus widths, the arbiter state encodings
//                and the owner encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_22041412_cache_rd_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 64;
    localparam int c_LEN_W  = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t c_ST_IDLE  = 2'b00;
    localparam arb_state_t c_ST_GRANT = 2'b01;
    localparam arb_state_t c_ST_HOLD  = 2'b10;

    localparam logic c_OWN_ICACHE = 1'b0;
    localparam logic c_OWN_DCACHE = 1'b1;

endpackage : ysyx_22041412_cache_rd_arb_pkg
`default_nettype wire

// File: rtl/ysyx_22041412_cache_rd_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041412_cache_rd_arb_if
//  Description : Bundle of every handshake/bus signal around the refill
//                read arbiter: Icache side (i_*), Dcache side (d_*), the
//                shared AXI read bridge (axi_*) and status (busy_o/owner_o).
//                slave  : arbiter view (caches/bridge drive inputs)
//                master : environment view (drives caches and bridge)
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_22041412_cache_rd_arb_if
    import ysyx_22041412_cache_rd_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
) ();

    // Icache refill port
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic              i_ready;
    logic              i_last;
    logic [DATA_W-1:0] i_data;

    // Dcache refill port
    logic              d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [LEN_W-1:0]  d_len;
    logic              d_ready;
    logic              d_last;
    logic [DATA_W-1:0] d_data;

    // Shared AXI read bridge
    logic              axi_valid_o;
    logic [ADDR_W-1:0] axi_addr_o;
    logic [LEN_W-1:0]  axi_len_o;
    logic              axi_ready_i;
    logic              axi_last_i;
    logic [DATA_W-1:0] axi_data_i;

    // Status
    logic              busy_o;
    logic              owner_o;

    modport slave (
        input  i_valid, i_addr, i_len,
        output i_ready, i_last, i_data,
        input  d_valid, d_addr, d_len,
        output d_ready, d_last, d_data,
        output axi_valid_o, axi_addr_o, axi_len_o,
        input  axi_ready_i, axi_last_i, axi_data_i,
        output busy_o, owner_o
    );

    modport master (
        output i_valid, i_addr, i_len,
        input  i_ready, i_last, i_data,
        output d_valid, d_addr, d_len,
        input  d_ready, d_last, d_data,
        input  axi_valid_o, axi_addr_o, axi_len_o,
        output axi_ready_i, axi_last_i, axi_data_i,
        input  busy_o, owner_o
    );

endinterface : ysyx_22041412_cache_rd_arb_if
`default_nettype wire

// File: rtl/ysyx_22041412_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041412_rr_pick2
//  Description : Two-input round-robin picker. A lone requester always wins;
//                on contention the requester named by rr_ptr wins.
//  Ports       : valid[1:0] requests (bit 0 = Icache, bit 1 = Dcache)
//                rr_ptr     preferred index on contention
//                any        at least one request present
//                grant      winning index (meaningful only when any = 1)
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22041412_rr_pick2 (
    input  wire logic [1:0] valid,
    input  wire logic       rr_ptr,
    output logic            any,
    output logic            grant
);

    assign any   = |valid;
    assign grant = (&valid) ? rr_ptr : valid[1];

endmodule : ysyx_22041412_rr_pick2
`default_nettype wire

// File: rtl/ysyx_22041412_cache_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22041412_cache_rd_arb
//  Description : Read-channel arbiter between the Icache and Dcache refill
//                ports and the single AXI read bridge. One cache owns a whole
//                burst; its address/length are latched at grant and held
//                stable, returning beats are steered combinationally to the
//                owner only, and ownership alternates on contention.
//  Ports       : clk, rst  clock and synchronous active-high reset
//                bus       ysyx_22041412_cache_rd_arb_if.slave (all cache,
//                          bridge and status signals)
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22041412_cache_rd_arb
    import ysyx_22041412_cache_rd_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    ysyx_22041412_cache_rd_arb_if.slave  bus
);

    arb_state_t        r_state;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_axi_valid;
    logic              r_busy;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_len_err;

    logic              w_any;
    logic              w_pick;
    logic              w_cnt_hit;
    logic              w_fwd;
    logic              w_to_i;
    logic              w_to_d;

    ysyx_22041412_rr_pick2 u_pick (
        .valid  ({bus.d_valid, bus.i_valid}),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .grant  (w_pick)
    );

    // The beat being accepted is the one whose index equals the latched len;
    // it must be the only beat flagged last.
    assign w_cnt_hit = (r_cnt == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= 1'b0;
            r_owner     <= c_OWN_ICACHE;
            r_addr      <= '0;
            r_len       <= '0;
            r_axi_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_len_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_pick;
                        r_addr      <= (w_pick == c_OWN_DCACHE) ? bus.d_addr : bus.i_addr;
                        r_len       <= (w_pick == c_OWN_DCACHE) ? bus.d_len  : bus.i_len;
                        r_cnt       <= '0;
                        r_axi_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    if (bus.axi_ready_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        // Early last or missing last: the burst still ends
                        // only on axi_last_i, but the mismatch is recorded.
                        if (bus.axi_last_i != w_cnt_hit) begin
                            r_len_err <= 1'b1;
                        end
                        if (bus.axi_last_i) begin
                            r_axi_valid <= 1'b0;
                            r_rr_ptr    <= ~r_owner;
                            r_state     <= c_ST_HOLD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    // One dead cycle so a cache still showing its registered
                    // valid after its last beat is not granted again.
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_axi_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Beats are only forwarded while a burst is granted, and only to its owner.
    assign w_fwd  = (r_state == c_ST_GRANT);
    assign w_to_i = w_fwd & (r_owner == c_OWN_ICACHE);
    assign w_to_d = w_fwd & (r_owner == c_OWN_DCACHE);

    assign bus.i_ready = w_to_i & bus.axi_ready_i;
    assign bus.i_last  = w_to_i & bus.axi_last_i;
    assign bus.i_data  = w_to_i ? bus.axi_data_i : '0;

    assign bus.d_ready = w_to_d & bus.axi_ready_i;
    assign bus.d_last  = w_to_d & bus.axi_last_i;
    assign bus.d_data  = w_to_d ? bus.axi_data_i : '0;

    assign bus.axi_valid_o = r_axi_valid;
    assign bus.axi_addr_o  = r_addr;
    assign bus.axi_len_o   = r_len;
    assign bus.busy_o      = r_busy;
    assign bus.owner_o     = r_owner;

endmodule : ysyx_22041412_cache_rd_arb
`default_nettype wire

// File: tb/tb_ysyx_22041412_cache_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22041412_cache_rd_arb
//  Description : Self-checking bench for the I/D cache read arbiter. A
//                transaction-level model tracks the round-robin preference
//                and the sticky length-error flag; directed scenarios are
//                followed by randomized request/burst traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_22041412_cache_rd_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ysyx_22041412_cache_rd_arb_if bus ();

    ysyx_22041412_cache_rd_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;

    // Model state: who wins the next contention, and whether any burst so
    // far (since reset) delivered a beat count other than len + 1.
    logic m_rr  = 1'b0;
    logic m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_owner(input logic own);
        if (own) bus.d_valid = 1'b0;
        else     bus.i_valid = 1'b0;
    endtask

    // Runs one complete arbitration + burst starting between edges with the
    // DUT idle. nb <= 0 delivers len+1 beats, otherwise exactly nb beats.
    // The non-owner's request is left as given (still pending).
    task automatic burst(input logic iv, input logic dv,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [7:0] il, input logic [7:0] dl,
                         input int nb, input bit drop_mid, input bit keep_after,
                         output logic own);
        logic [31:0] ea;
        logic [7:0]  el;
        logic [63:0] dat;
        int          nbeats;
        own    = (iv && dv) ? m_rr : dv;
        ea     = own ? da : ia;
        el     = own ? dl : il;
        nbeats = (nb > 0) ? nb : int'(el) + 1;
        bus.i_valid = iv; bus.i_addr = ia; bus.i_len = il;
        bus.d_valid = dv; bus.d_addr = da; bus.d_len = dl;
        @(posedge clk); @(negedge clk);
        chk("grant_axi_valid", bus.axi_valid_o, 1);
        chk("grant_addr", bus.axi_addr_o, ea);
        chk("grant_len", bus.axi_len_o, el);
        chk("grant_owner", bus.owner_o, own);
        chk("grant_busy", bus.busy_o, 1);
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.axi_ready_i = 1'b0; bus.axi_last_i = 1'b0; bus.axi_data_i = {$urandom, $urandom};
                #1;
                chk("gap_i_ready", bus.i_ready, 0);
                chk("gap_d_ready", bus.d_ready, 0);
                @(posedge clk); @(negedge clk);
            end
            dat = {$urandom, $urandom};
            bus.axi_ready_i = 1'b1;
            bus.axi_last_i  = (b == nbeats - 1);
            bus.axi_data_i  = dat;
            #1;
            chk("beat_axi_valid", bus.axi_valid_o, 1);
            chk("beat_addr_stable", bus.axi_addr_o, ea);
            chk("beat_own_ready", own ? bus.d_ready : bus.i_ready, 1);
            chk("beat_own_last", own ? bus.d_last : bus.i_last, (b == nbeats - 1));
            chk("beat_own_data", own ? bus.d_data : bus.i_data, dat);
            chk("beat_oth_ready", own ? bus.i_ready : bus.d_ready, 0);
            chk("beat_oth_last", own ? bus.i_last : bus.d_last, 0);
            chk("beat_oth_data", own ? bus.i_data : bus.d_data, 0);
            @(posedge clk); @(negedge clk);
            if (drop_mid) drop_owner(own);
        end
        bus.axi_ready_i = 1'b0; bus.axi_last_i = 1'b0;
        if (!keep_after) drop_owner(own);
        if (nbeats != int'(el) + 1) m_err = 1'b1;
        m_rr = ~own;
        #1;
        chk("hold_axi_valid", bus.axi_valid_o, 0);
        chk("hold_busy", bus.busy_o, 1);
        chk("hold_len_err", dut.r_len_err, m_err);
        @(posedge clk); @(negedge clk);
        drop_owner(own);
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_axi_valid", bus.axi_valid_o, 0);
        chk("idle_rr_ptr", dut.r_rr_ptr, m_rr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_axi_valid", bus.axi_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_owner", bus.owner_o, 0);
        chk("rst_addr", bus.axi_addr_o, 0);
        chk("rst_len", bus.axi_len_o, 0);
        chk("rst_rr_ptr", dut.r_rr_ptr, 0);
        chk("rst_len_err", dut.r_len_err, 0);
        rst = 1'b0;
        m_rr = 1'b0; m_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        own;
        logic        pend_i, pend_d;
        logic [31:0] ia, da;
        logic [7:0]  il, dl;
        int          nb;

        bus.i_valid = 0; bus.i_addr = '0; bus.i_len = '0;
        bus.d_valid = 0; bus.d_addr = '0; bus.d_len = '0;
        bus.axi_ready_i = 0; bus.axi_last_i = 0; bus.axi_data_i = '0;

        do_reset();
        chk("rst_i_ready", bus.i_ready, 0);
        chk("rst_d_ready", bus.d_ready, 0);

        // Icache alone, two beats.
        burst(1, 0, 32'h8000_0010, 32'h0, 8'd1, 8'd0, 0, 0, 0, own);
        chk("solo_owner_icache", own, 0);

        // Fresh reset, then simultaneous requests: Icache, then Dcache at
        // N+3 (its valid is held throughout), then Icache again.
        do_reset();
        burst(1, 1, 32'h8000_0040, 32'h8000_1000, 8'd1, 8'd3, 0, 0, 0, own);
        chk("both_first_icache", own, 0);
        burst(0, 1, 32'h8000_0040, 32'h8000_1000, 8'd1, 8'd3, 0, 0, 0, own);
        chk("both_second_dcache", own, 1);
        burst(1, 1, 32'h8000_0080, 32'h8000_2000, 8'd0, 8'd0, 0, 0, 0, own);
        chk("both_third_icache", own, 0);
        burst(0, 1, 32'h8000_0080, 32'h8000_2000, 8'd0, 8'd0, 0, 0, 0, own);

        // Icache keeps valid through HOLD: no second grant.
        burst(1, 0, 32'h8000_0100, 32'h0, 8'd1, 8'd0, 0, 0, 1, own);
        @(posedge clk); @(negedge clk);
        chk("stale_no_regrant", bus.axi_valid_o, 0);
        chk("stale_not_busy", bus.busy_o, 0);

        // Dcache drops valid after its first beat: burst still completes.
        burst(0, 1, 32'h0, 32'h8000_3000, 8'd0, 8'd1, 0, 1, 0, own);
        chk("drop_owner_dcache", own, 1);

        // Randomized traffic; pending requests stay asserted until served.
        pend_i = 0; pend_d = 0; ia = '0; da = '0; il = '0; dl = '0;
        for (int it = 0; it < 40; it++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; ia = $urandom & 32'hFFFF_FFC0; il = 8'($urandom_range(0, 3));
            end
            if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i)) begin
                pend_d = 1; da = $urandom & 32'hFFFF_FFC0; dl = 8'($urandom_range(0, 3));
            end
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
            burst(pend_i, pend_d, ia, da, il, dl, nb, 0, 0, own);
            if (own) pend_d = 0;
            else     pend_i = 0;
        end
        if (pend_i || pend_d) burst(pend_i, pend_d, ia, da, il, dl, 0, 0, 0, own);

        // Reset in the middle of a burst.
        bus.i_valid = 1; bus.i_addr = 32'h8000_0200; bus.i_len = 8'd1;
        @(posedge clk); @(negedge clk);
        chk("rstmid_granted", bus.axi_valid_o, 1);
        bus.axi_ready_i = 1; bus.axi_last_i = 0; bus.axi_data_i = 64'hAAAA;
        rst = 1;
        @(posedge clk); @(negedge clk);
        chk("rstmid_axi_valid", bus.axi_valid_o, 0);
        chk("rstmid_busy", bus.busy_o, 0);
        chk("rstmid_i_ready", bus.i_ready, 0);
        chk("rstmid_i_data", bus.i_data, 0);
        chk("rstmid_state", dut.r_state, 0);
        chk("rstmid_rr_ptr", dut.r_rr_ptr, 0);
        chk("rstmid_len_err", dut.r_len_err, 0);
        rst = 0; bus.i_valid = 0; bus.axi_ready_i = 0;
        m_rr = 0; m_err = 0;
        @(posedge clk); @(negedge clk);
        chk("rstmid_ready_ignored", bus.i_ready, 0);

        // Early last with len = 1: burst ends, error flag becomes sticky.
        burst(0, 1, 32'h0, 32'h8000_4000, 8'd0, 8'd1, 1, 0, 0, own);
        chk("early_last_err", dut.r_len_err, 1);
        burst(1, 0, 32'h8000_5000, 32'h0, 8'd2, 8'd0, 0, 0, 0, own);
        chk("err_sticky", dut.r_len_err, 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ysyx_22041412_cache_rd_arb
`default_nettype wire

// File: doc/ysyx_22041412_cache_rd_arb.md
# ysyx_22041412_cache_rd_arb

Two-master read-channel arbiter between the instruction cache and data cache refill ports and the single shared AXI read master. Grants one cache a complete burst at a time, registers the winner's address and length, forwards returning beats to the owner only, and round-robins between masters so neither starves. Sits between `ysyx_22041412_Icache`/Dcache and the AXI bridge.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, beat data width
- `LEN_W`, 8, burst length field width (beats = len + 1)

Ports (prefix `i_` = Icache side, `d_` = Dcache side; both sides identical):
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_valid`/`d_valid`  in  1  refill request, held until last beat returned
- `i_addr`/`d_addr`  in  ADDR_W  line-aligned burst address
- `i_len`/`d_len`  in  LEN_W  burst length
- `i_ready`/`d_ready`  out  1  beat valid to this master
- `i_last`/`d_last`  out  1  final beat of this master's burst
- `i_data`/`d_data`  out  DATA_W  beat data
- `axi_valid_o`  out  1  read request to bridge
- `axi_addr_o`  out  ADDR_W  latched owner address
- `axi_len_o`  out  LEN_W  latched owner length
- `axi_ready_i`  in  1  beat valid from bridge
- `axi_last_i`  in  1  final beat from bridge
- `axi_data_i`  in  DATA_W  beat data
- `busy_o`  out  1  state != IDLE
- `owner_o`  out  1  0 = Icache, 1 = Dcache (valid while busy)

## Operation
- States: IDLE, GRANT, HOLD.
- IDLE: if neither valid, stay. If one valid, grant it. If both, grant master indicated by `rr_ptr` (0 = Icache). On grant: latch addr/len, set owner, -> GRANT.
- GRANT: `axi_valid_o`=1 with latched addr/len (stable for entire burst, independent of master inputs). Owner's `ready/last/data` = `axi_ready_i/axi_last_i/axi_data_i`; non-owner ready/last = 0, data = 0. Beat counter increments on each `axi_ready_i`.
- `axi_ready_i & axi_last_i` in GRANT: drop `axi_valid_o` next cycle, `rr_ptr` <= ~owner, -> HOLD.
- HOLD: exactly one cycle, all requests ignored (masters drop registered valid the cycle after last; prevents stale re-grant). -> IDLE.
- Owner deasserting valid mid-burst: no abort; burst completes, beats still routed to owner.
- `axi_last_i` arriving before counter reaches len, or counter passing len without last: burst still ends on `axi_last_i` only; sticky `len_err` flag raised (internal, visible to bench via hierarchy), cleared only by reset.
- `axi_ready_i` outside GRANT: ignored, not forwarded.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, all outputs 0, counter 0, `len_err` 0.
- Request-to-`axi_valid_o` latency: 1 cycle (valid seen in IDLE at cycle N, `axi_valid_o` high at N+1).
- Beat forwarding: combinational, zero added latency.
- Back-to-back: last beat at cycle N -> HOLD at N+1 -> IDLE at N+2 -> next `axi_valid_o` at N+3.
- Reset asserted mid-burst: all outputs 0 the following cycle; no partial completion signalled.

## Structure
- Shared package/header: state encodings (IDLE=2'b00, GRANT=2'b01, HOLD=2'b10), owner encodings, default widths.
- One natural sub-module: `ysyx_22041412_rr_pick2` (2-input round-robin picker: valids + `rr_ptr` -> grant index). Rest is a flat FSM + latch + mux.

## Test plan
- Icache alone, addr 0x8000_0010, len 1, bridge returns 0xAAAA/0xBBBB -> `axi_valid_o` 1 cycle later with addr 0x8000_0010, i_ready on both beats, i_last on second, d_ready never high.
- Both valid same cycle after reset -> Icache granted first; after its last beat + HOLD, Dcache granted at N+3; next simultaneous request grants Icache again.
- Icache keeps `i_valid` high one cycle after last -> no second grant (HOLD absorbs it); `axi_valid_o` stays low.
- Dcache drops `d_valid` after first of 2 beats -> `axi_valid_o` held until `axi_last_i`, second beat on d_ready, then IDLE.
- `rst` pulsed during beat 1 of 2 -> next cycle all outputs 0, state IDLE, `rr_ptr`=0.
- `axi_last_i` on beat 1 with len=1 -> burst ends, `len_err`=1 and remains 1 until reset.
